onehot_decoder_scan: RTL and testbench
======================================

Name: onehot_decoder_scan

Overview:
Parametrised, registered N-to-M one-hot decoder with valid/ready handshakes on its input and output. It is the successor to the fixed 4-to-16 combinational decoder. It adds a second mode, autonomous scan, in which an internal counter walks the one-hot output across all lines with a programmable dwell per line. It drives row/digit select lines and register-bank enables.

Parameters:
SEL_W, 4, width of select index
NUM_OUT, 16, number of one-hot output lines; legal range 2..2**SEL_W
DWELL, 4, cycles each line is held in scan mode; minimum 1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = decode, 1 = scan
in_valid  input  1  in_sel is valid
in_ready  output  1  block accepts in_sel this cycle
in_sel  input  SEL_W  index to decode
out_valid  output  1  out_onehot is valid
out_ready  input  1  downstream consumes out_onehot
out_onehot  output  NUM_OUT  registered one-hot (or all-zero) word
scan_idx  output  SEL_W  index currently driven in scan mode; 0 otherwise

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously to clk):
  - State IDLE.
  - out_valid=0, out_onehot=0, scan_idx=0.
  - Dwell counter 0.
  - Reset mid-transfer discards the pending word.
- Combinational handshake: in_ready = (mode==0) && (state!=SCAN) && (!out_valid || out_ready).
- Accept when in_valid && in_ready. Next cycle:
  - out_valid=1.
  - out_onehot = 1<<in_sel if in_sel<NUM_OUT, else all-zero. An all-zero word is still a valid transfer.
  - Latency is 1 cycle.
- State IDLE:
  - Accept -> HOLD.
  - mode=1 -> SCAN; next cycle out_onehot=bit0, scan_idx=0, out_valid=1, dwell=0.
- State HOLD:
  - out_onehot is stable while out_valid && !out_ready.
  - out_ready with simultaneous accept -> stay in HOLD with the new word (back-to-back, full throughput).
  - out_ready without accept -> IDLE, out_valid=0, out_onehot=0.
  - mode=1 while in HOLD: no new accepts; the pending word drains first, then the block goes to SCAN, not IDLE.
- State SCAN:
  - out_valid=1 throughout.
  - Dwell counter increments only on cycles with out_ready=1.
  - When dwell==DWELL-1 and out_ready: dwell<=0, scan_idx<=scan_idx+1, wrapping NUM_OUT-1 -> 0. out_onehot follows scan_idx.
  - out_ready=0 freezes both counters and the output.
  - DWELL=1: advance every cycle that out_ready=1.
  - mode=0: next cycle IDLE, out_valid=0, out_onehot=0, scan_idx=0, dwell=0. Any in-progress dwell is abandoned.
- in_sel is ignored whenever in_ready=0.
- Exactly one out_onehot bit is set, except for an out-of-range decode (all-zero) and during IDLE (all-zero).

Optional Feature:
Macro ONEHOT_DEC_ERR_EN.
- Defined:
  - Extra output err_sticky (1 bit, reset 0).
  - Extra input err_clr (1 bit, synchronous).
  - err_sticky is set on any accepted in_sel>=NUM_OUT.
  - err_sticky is cleared by err_clr=1. If a set and a clear occur in the same cycle, set wins.
- Undefined: neither port exists; out-of-range indices silently produce all-zero words.

Test Plan:
All scenarios use SEL_W=4, NUM_OUT=12, DWELL=3.
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_onehot=0x000, scan_idx=0. Assert rst_n low asynchronously mid-HOLD -> outputs clear before the next edge.
- Decode stream: mode=0, out_ready=1, in_sel=0,5,11 on consecutive cycles -> out_onehot=0x001,0x020,0x800 one cycle later each; in_ready stays 1.
- Backpressure: in_sel=3 accepted, out_ready=0 for 4 cycles -> out_onehot=0x008 held, in_ready=0. out_ready=1 together with in_sel=7 -> next word 0x080.
- Out-of-range: in_sel=13 -> out_valid=1, out_onehot=0x000. With ONEHOT_DEC_ERR_EN, err_sticky=1 until err_clr.
- Scan wrap: mode=1, out_ready=1 -> each index is held 3 cycles: 0x001 x3, 0x002 x3, ... 0x800 x3, then 0x001. scan_idx goes 11->0. Drop out_ready for 2 cycles mid-dwell -> the dwell is extended by exactly 2 cycles.
- Mode switch: mode=1 while a decode word is pending and out_ready=0 -> the word is held. After out_ready=1, SCAN starts at 0x001 the next cycle. Then mode=0 -> out_valid=0 one cycle later.

Source files
------------

// File: rtl/onehot_decoder_scan_if.sv
// Handshake bundle for onehot_decoder_scan: select input channel, one-hot output channel, mode and scan index.
// master: upstream/downstream side (drives mode, in_valid, in_sel, out_ready); slave: the decoder.
// Optional ONEHOT_DEC_ERR_EN adds err_clr (to decoder) and err_sticky (from decoder).
interface onehot_decoder_scan_if #(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16
);
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_onehot;
  logic [SEL_W-1:0]   scan_idx;
`ifdef ONEHOT_DEC_ERR_EN
  logic               err_clr;
  logic               err_sticky;
`endif

  modport master (
    output mode, in_valid, in_sel, out_ready,
`ifdef ONEHOT_DEC_ERR_EN
    output err_clr,
    input  err_sticky,
`endif
    input  in_ready, out_valid, out_onehot, scan_idx
  );

  modport slave (
    input  mode, in_valid, in_sel, out_ready,
`ifdef ONEHOT_DEC_ERR_EN
    input  err_clr,
    output err_sticky,
`endif
    output in_ready, out_valid, out_onehot, scan_idx
  );
endinterface

// File: rtl/onehot_decoder_scan.sv
// Registered N-to-M one-hot decoder with an autonomous scan mode (walks the output with a per-line dwell).
// Latency: 1 cycle from accepted in_sel to out_onehot; scan starts the cycle after mode=1 is seen idle/drained.
// Backpressure: in_ready drops while out_valid && !out_ready, in scan mode, or when mode=1; out_ready=0 freezes scan.
// Ports: clk, rst_n (async active-low), bus (onehot_decoder_scan_if.slave).
// Optional: define ONEHOT_DEC_ERR_EN to add err_sticky/err_clr for out-of-range select tracking.
module onehot_decoder_scan #(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16,
  parameter int DWELL   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_decoder_scan_if.slave bus
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t             state_q;
  logic               out_valid_q;
  logic [NUM_OUT-1:0] onehot_q;
  logic [SEL_W-1:0]   scan_idx_q;
  logic [DW_W-1:0]    dwell_q;

  logic               in_ready;
  logic               accept;
  logic               sel_oor;
  logic [NUM_OUT-1:0] dec_d;
  logic [SEL_W-1:0]   scan_idx_d;
  logic               dwell_end;

  // Scan owns the output, and mode=1 blocks new words so a pending one can drain before scan.
  assign in_ready = !bus.mode && (state_q != SCAN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    sel_oor    = 32'(bus.in_sel) >= NUM_OUT;
    dec_d      = sel_oor ? '0 : (NUM_OUT'(1) << bus.in_sel);
    scan_idx_d = (scan_idx_q == SEL_W'(NUM_OUT - 1)) ? '0 : scan_idx_q + SEL_W'(1);
    dwell_end  = (dwell_q == DW_W'(DWELL - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      scan_idx_q  <= '0;
      dwell_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            onehot_q    <= dec_d;
          end else if (bus.mode) begin
            state_q     <= SCAN;
            out_valid_q <= 1'b1;
            onehot_q    <= NUM_OUT'(1);
            scan_idx_q  <= '0;
            dwell_q     <= '0;
          end
        end
        HOLD: begin
          if (accept) begin
            // Back-to-back: the new word replaces the one consumed this cycle.
            onehot_q <= dec_d;
          end else if (bus.out_ready) begin
            if (bus.mode) begin
              state_q     <= SCAN;
              out_valid_q <= 1'b1;
              onehot_q    <= NUM_OUT'(1);
              scan_idx_q  <= '0;
              dwell_q     <= '0;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              onehot_q    <= '0;
            end
          end
        end
        SCAN: begin
          if (!bus.mode) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            onehot_q    <= '0;
            scan_idx_q  <= '0;
            dwell_q     <= '0;
          end else if (bus.out_ready) begin
            // Dwell only counts cycles the consumer actually took the word.
            if (dwell_end) begin
              dwell_q    <= '0;
              scan_idx_q <= scan_idx_d;
              onehot_q   <= NUM_OUT'(1) << scan_idx_d;
            end else begin
              dwell_q <= dwell_q + DW_W'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          onehot_q    <= '0;
          scan_idx_q  <= '0;
          dwell_q     <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_onehot = onehot_q;
  assign bus.scan_idx   = scan_idx_q;

`ifdef ONEHOT_DEC_ERR_EN
  logic err_sticky_q;

  // A new out-of-range accept outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (accept && sel_oor) begin
      err_sticky_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign bus.err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_scan.sv
module tb_onehot_decoder_scan;
  localparam int SEL_W   = 4;
  localparam int NUM_OUT = 12;
  localparam int DWELL   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onehot_decoder_scan_if #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) bus ();

  onehot_decoder_scan #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a pending word (valid + value), or a scan described only by the count of
  // consumed scan cycles; the visible line is (ticks / DWELL) mod NUM_OUT.
  logic        m_valid;
  logic [11:0] m_word;
  logic        m_scan;
  int          m_ticks;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    logic rdy, acc, clr;
    if (!rst_n) begin
      m_valid = 1'b0; m_word = '0; m_scan = 1'b0; m_ticks = 0; m_err = 1'b0;
    end else begin
      rdy = !bus.mode && !m_scan && (!m_valid || bus.out_ready);
      acc = bus.in_valid && rdy;
`ifdef ONEHOT_DEC_ERR_EN
      clr = bus.err_clr;
`else
      clr = 1'b0;
`endif
      if (acc && int'(bus.in_sel) >= NUM_OUT) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      if (m_scan) begin
        if (!bus.mode) begin
          m_scan = 1'b0; m_valid = 1'b0; m_word = '0; m_ticks = 0;
        end else if (bus.out_ready) begin
          m_ticks++;
        end
      end else if (acc) begin
        m_valid = 1'b1;
        m_word  = (int'(bus.in_sel) < NUM_OUT) ? (12'(1) << bus.in_sel) : 12'h000;
      end else if (bus.mode && (!m_valid || bus.out_ready)) begin
        m_scan = 1'b1; m_ticks = 0; m_valid = 1'b1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0; m_word = '0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int          idx;
    logic [11:0] word;
    idx  = m_scan ? (m_ticks / DWELL) % NUM_OUT : 0;
    word = m_scan ? (12'(1) << idx) : m_word;
    cmp("model out_valid", 32'(bus.out_valid), 32'(m_scan || m_valid));
    cmp("model out_onehot", 32'(bus.out_onehot), 32'(word));
    cmp("model scan_idx", 32'(bus.scan_idx), 32'(idx));
    cmp("model in_ready", 32'(bus.in_ready),
        32'(!bus.mode && !m_scan && (!m_valid || bus.out_ready)));
`ifdef ONEHOT_DEC_ERR_EN
    cmp("model err_sticky", 32'(bus.err_sticky), 32'(m_err));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input logic iv, input logic [3:0] sel, input logic ordy);
    bus.mode = md; bus.in_valid = iv; bus.in_sel = sel; bus.out_ready = ordy;
  endtask

  initial begin
`ifdef ONEHOT_DEC_ERR_EN
    bus.err_clr = 1'b0;
`endif
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
      tick();
      cmp("rst out_valid", 32'(bus.out_valid), 32'h0);
      cmp("rst out_onehot", 32'(bus.out_onehot), 32'h000);
      cmp("rst scan_idx", 32'(bus.scan_idx), 32'h0);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    rst_n = 1'b1;
    tick();

    // Decode stream 0, 5, 11.
    drive(1'b0, 1'b1, 4'd0, 1'b1);
    cmp("stream in_ready pre", 32'(bus.in_ready), 32'h1);
    tick(); cmp("stream sel0", 32'(bus.out_onehot), 32'h001);
    cmp("stream valid", 32'(bus.out_valid), 32'h1);
    bus.in_sel = 4'd5;  tick(); cmp("stream sel5", 32'(bus.out_onehot), 32'h020);
    bus.in_sel = 4'd11; tick(); cmp("stream sel11", 32'(bus.out_onehot), 32'h800);
    cmp("stream in_ready", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 1'b0; tick();
    cmp("stream drained", 32'(bus.out_valid), 32'h0);

    // Backpressure.
    drive(1'b0, 1'b1, 4'd3, 1'b1); tick();
    drive(1'b0, 1'b1, 4'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("bp held word", 32'(bus.out_onehot), 32'h008);
      cmp("bp in_ready", 32'(bus.in_ready), 32'h0);
    end
    drive(1'b0, 1'b1, 4'd7, 1'b1); tick();
    cmp("bp next word", 32'(bus.out_onehot), 32'h080);
    bus.in_valid = 1'b0; tick();

    // Out-of-range select.
    drive(1'b0, 1'b1, 4'd13, 1'b1); tick();
    cmp("oor valid", 32'(bus.out_valid), 32'h1);
    cmp("oor word", 32'(bus.out_onehot), 32'h000);
`ifdef ONEHOT_DEC_ERR_EN
    cmp("err set", 32'(bus.err_sticky), 32'h1);
    bus.in_valid = 1'b0; tick(); cmp("err sticky", 32'(bus.err_sticky), 32'h1);
    bus.err_clr = 1'b1; tick(); cmp("err cleared", 32'(bus.err_sticky), 32'h0);
    drive(1'b0, 1'b1, 4'd14, 1'b1); tick();
    cmp("err set beats clr", 32'(bus.err_sticky), 32'h1);
    bus.err_clr = 1'b0;
`endif
    bus.in_valid = 1'b0; tick();
    cmp("oor drained", 32'(bus.out_valid), 32'h0);

    // Scan wrap.
    drive(1'b1, 1'b0, 4'd0, 1'b1); tick();
    cmp("scan start word", 32'(bus.out_onehot), 32'h001);
    cmp("scan start idx", 32'(bus.scan_idx), 32'h0);
    for (int k = 1; k <= 36; k++) begin
      tick();
      cmp("scan walk", 32'(bus.out_onehot), 32'(12'(1) << ((k / 3) % 12)));
      if (k == 35) cmp("scan idx 11", 32'(bus.scan_idx), 32'd11);
    end
    cmp("scan wrap idx", 32'(bus.scan_idx), 32'd0);
    tick(); cmp("dwell 2nd", 32'(bus.out_onehot), 32'h001);
    bus.out_ready = 1'b0;
    tick(); cmp("dwell frozen1", 32'(bus.out_onehot), 32'h001);
    tick(); cmp("dwell frozen2", 32'(bus.out_onehot), 32'h001);
    bus.out_ready = 1'b1;
    tick(); cmp("dwell 3rd", 32'(bus.out_onehot), 32'h001);
    tick(); cmp("dwell advance", 32'(bus.out_onehot), 32'h002);
    bus.mode = 1'b0; tick();
    cmp("scan exit valid", 32'(bus.out_valid), 32'h0);
    cmp("scan exit idx", 32'(bus.scan_idx), 32'h0);

    // Mode switch while a word is pending.
    drive(1'b0, 1'b1, 4'd2, 1'b0); tick();
    cmp("ms word", 32'(bus.out_onehot), 32'h004);
    drive(1'b1, 1'b1, 4'd6, 1'b0);
    tick(); cmp("ms held", 32'(bus.out_onehot), 32'h004);
    tick(); cmp("ms in_ready", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1; tick();
    cmp("ms scan word", 32'(bus.out_onehot), 32'h001);
    cmp("ms scan valid", 32'(bus.out_valid), 32'h1);
    drive(1'b0, 1'b0, 4'd0, 1'b1); tick();
    cmp("ms exit valid", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset while holding a word.
    drive(1'b0, 1'b1, 4'd4, 1'b0); tick();
    cmp("ar word", 32'(bus.out_onehot), 32'h010);
    #2 rst_n = 1'b0;
    #1;
    cmp("ar async valid", 32'(bus.out_valid), 32'h0);
    cmp("ar async word", 32'(bus.out_onehot), 32'h000);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    rst_n = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
